// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit (with mem_access_pkg)
// Brief    : Load/store/fetch engine issuing one Wishbone-classic single-beat
//            transaction per request. It steers byte lanes, replicates store
//            data, and extracts and extends load data. Misalignment, bus
//            errors and timeouts are reported back to the control unit.
// Revision : 1.0 - initial release
// ============================================================================

package mem_access_pkg;
    typedef enum logic [1:0] {
        MEM_NONE   = 2'b00,
        LOAD_DATA  = 2'b01,
        STORE_DATA = 2'b10,
        FETCH_DATA = 2'b11
    } memory_operation_t;

    // Encoding 2'b11 is deliberately unused and treated as an illegal size.
    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } access_size_t;
endpackage

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  memory_operation_t op,
    input  access_size_t      size,
    input  logic              unsigned_load,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              fault_misaligned,
    output logic              fault_bus,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [3:0]        wb_sel_o,
    output logic [31:0]       wb_adr_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    localparam logic [1:0]  c_idle     = 2'd0;
    localparam logic [1:0]  c_bus      = 2'd1;
    localparam logic [1:0]  c_resp     = 2'd2;
    // Last count value still inside the allowed bus window.
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]   r_state;
    logic [15:0]  r_count;
    access_size_t r_size;
    logic         r_unsigned;
    logic [1:0]   r_offset;
    logic         r_is_load;

    logic         w_is_fetch;
    logic         w_misaligned;
    logic [3:0]   w_sel;
    logic [31:0]  w_wdata;
    logic [31:0]  w_shifted;
    logic [31:0]  w_extended;
    logic         w_timeout;

    assign w_is_fetch = (op == FETCH_DATA);
    assign busy       = (r_state == c_bus) || (r_state == c_resp);
    assign w_timeout  = (r_count == c_tmo_last);

    // Alignment check; a fetch is always a full word regardless of size.
    always_comb begin
        w_misaligned = 1'b0;
        if (2'(size) == 2'b11)
            w_misaligned = 1'b1;
        else if (w_is_fetch || size == WORD)
            w_misaligned = (addr[1:0] != 2'b00);
        else if (size == HALF_WORD)
            w_misaligned = addr[0];
    end

    // Byte-lane selects and replicated store data for the request.
    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = store_data;
        if (!w_is_fetch) begin
            case (size)
                BYTE: begin
                    w_sel   = 4'b0001 << addr[1:0];
                    w_wdata = {4{store_data[7:0]}};
                end
                HALF_WORD: begin
                    w_sel   = 4'b0011 << addr[1:0];
                    w_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    w_sel   = 4'b1111;
                    w_wdata = store_data;
                end
            endcase
        end
    end

    // Move the addressed lane down to bit 0, then sign- or zero-extend it.
    assign w_shifted = wb_dat_i >> {r_offset, 3'b000};

    always_comb begin
        case (r_size)
            BYTE:      w_extended = {{24{~r_unsigned & w_shifted[7]}},  w_shifted[7:0]};
            HALF_WORD: w_extended = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default:   w_extended = w_shifted;
        endcase
    end

    // Request sequencing: IDLE accepts, BUS waits for ack/err/timeout, RESP pulses done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= c_idle;
            r_count          <= 16'd0;
            r_size           <= BYTE;
            r_unsigned       <= 1'b0;
            r_offset         <= 2'b00;
            r_is_load        <= 1'b0;
            done             <= 1'b0;
            load_data        <= 32'd0;
            fault_misaligned <= 1'b0;
            fault_bus        <= 1'b0;
            wb_cyc_o         <= 1'b0;
            wb_stb_o         <= 1'b0;
            wb_we_o          <= 1'b0;
            wb_sel_o         <= 4'b0000;
            wb_adr_o         <= 32'd0;
            wb_dat_o         <= 32'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (req && op != MEM_NONE) begin
                        if (w_misaligned) begin
                            r_state          <= c_resp;
                            done             <= 1'b1;
                            fault_misaligned <= 1'b1;
                        end else begin
                            r_state    <= c_bus;
                            r_count    <= 16'd0;
                            r_size     <= w_is_fetch ? WORD : size;
                            r_unsigned <= w_is_fetch | unsigned_load;
                            r_offset   <= addr[1:0];
                            r_is_load  <= (op == LOAD_DATA) || w_is_fetch;
                            wb_cyc_o   <= 1'b1;
                            wb_stb_o   <= 1'b1;
                            wb_we_o    <= (op == STORE_DATA);
                            wb_sel_o   <= w_sel;
                            wb_adr_o   <= {addr[31:2], 2'b00};
                            wb_dat_o   <= w_wdata;
                        end
                    end
                end
                c_bus: begin
                    r_count <= r_count + 16'd1;
                    // Error takes priority over a simultaneous ack.
                    if (wb_err_i) begin
                        r_state   <= c_resp;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        done      <= 1'b1;
                        fault_bus <= 1'b1;
                    end else if (wb_ack_i) begin
                        r_state  <= c_resp;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        done     <= 1'b1;
                        if (r_is_load)
                            load_data <= w_extended;
                    end else if (w_timeout) begin
                        r_state   <= c_resp;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        done      <= 1'b1;
                        fault_bus <= 1'b1;
                    end
                end
                c_resp: begin
                    r_state          <= c_idle;
                    done             <= 1'b0;
                    fault_misaligned <= 1'b0;
                    fault_bus        <= 1'b0;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
